// File: rtl/id_ex_alu_stage_if.sv
// Interface for the ID/EX ALU stage: decode inputs, forwarding sources and EX-side outputs.
interface id_ex_alu_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              id_valid;
    logic [1:0]        id_alu_op;
    logic [5:0]        id_funct;
    logic [4:0]        id_shamt;
    logic              id_alu_src;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [REG_AW-1:0] id_rs_addr;
    logic [REG_AW-1:0] id_rt_addr;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_reg_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_mem_to_reg;
    logic              flush;
    logic              exmem_reg_write;
    logic [REG_AW-1:0] exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_reg_write;
    logic [REG_AW-1:0] memwb_rd;
    logic [DATA_W-1:0] memwb_result;
    logic              stall;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_operand_a;
    logic [DATA_W-1:0] ex_operand_b;
    logic [DATA_W-1:0] ex_store_data;
    logic [4:0]        ex_shamt;
    logic [3:0]        ex_alu_control;
    logic [REG_AW-1:0] ex_dest;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;

    modport master (
        output id_valid, id_alu_op, id_funct, id_shamt, id_alu_src, id_imm,
               id_rs_data, id_rt_data, id_rs_addr, id_rt_addr, id_rd_addr,
               id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               flush, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  stall, ex_valid, ex_operand_a, ex_operand_b, ex_store_data,
               ex_shamt, ex_alu_control, ex_dest, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_mem_to_reg
    );

    modport slave (
        input  id_valid, id_alu_op, id_funct, id_shamt, id_alu_src, id_imm,
               id_rs_data, id_rt_data, id_rs_addr, id_rt_addr, id_rd_addr,
               id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               flush, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output stall, ex_valid, ex_operand_a, ex_operand_b, ex_store_data,
               ex_shamt, ex_alu_control, ex_dest, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_mem_to_reg
    );
endinterface

// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register feeding the ALU: ALU-control decode, operand forwarding
// from EX/MEM and MEM/WB, and load-use hazard detection for decode.
module id_ex_alu_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input logic             clk,
    input logic             reset,
    id_ex_alu_stage_if.slave bus
);
    localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

    logic              valid_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [REG_AW-1:0] rs_addr_q;
    logic [REG_AW-1:0] rt_addr_q;
    logic [REG_AW-1:0] dest_q;
    logic              alu_src_q;
    logic [4:0]        shamt_q;
    logic [3:0]        alu_ctrl_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              mem_to_reg_q;

    logic [3:0]        alu_ctrl_d;
    logic              illegal_d;
    logic              stall_c;
    logic              capture;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // ALUOp/funct to ALU control code
    always_comb begin
        alu_ctrl_d = CTRL_ILLEGAL;
        case (bus.id_alu_op)
            2'b00: alu_ctrl_d = 4'b0010;
            2'b01: alu_ctrl_d = 4'b0110;
            2'b10: begin
                case (bus.id_funct)
                    6'b100000: alu_ctrl_d = 4'b0010;
                    6'b100010: alu_ctrl_d = 4'b0110;
                    6'b100100: alu_ctrl_d = 4'b0000;
                    6'b100111: alu_ctrl_d = 4'b1100;
                    6'b101010: alu_ctrl_d = 4'b0111;
                    6'b000000: alu_ctrl_d = 4'b1110;
                    default:   alu_ctrl_d = CTRL_ILLEGAL;
                endcase
            end
            default: alu_ctrl_d = CTRL_ILLEGAL;
        endcase
        illegal_d = (alu_ctrl_d == CTRL_ILLEGAL);
    end

    // Load in EX whose destination is read by the instruction in decode
    assign stall_c = valid_q & mem_read_q & (dest_q != '0) & bus.id_valid &
                     ((dest_q == bus.id_rs_addr) |
                      ((dest_q == bus.id_rt_addr) & (~bus.id_alu_src | bus.id_mem_write)));

    assign capture = bus.id_valid & ~stall_c & ~bus.flush;

    // Non-captured cycles load a fully cleared bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset || !capture) begin
            valid_q      <= 1'b0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            dest_q       <= '0;
            alu_src_q    <= 1'b0;
            shamt_q      <= '0;
            alu_ctrl_q   <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= 1'b1;
            rs_data_q    <= bus.id_rs_data;
            rt_data_q    <= bus.id_rt_data;
            imm_q        <= bus.id_imm;
            rs_addr_q    <= bus.id_rs_addr;
            rt_addr_q    <= bus.id_rt_addr;
            dest_q       <= bus.id_reg_dst ? bus.id_rd_addr : bus.id_rt_addr;
            alu_src_q    <= bus.id_alu_src;
            shamt_q      <= bus.id_shamt;
            alu_ctrl_q   <= alu_ctrl_d;
            reg_write_q  <= bus.id_reg_write & ~illegal_d;
            mem_read_q   <= bus.id_mem_read & ~illegal_d;
            mem_write_q  <= bus.id_mem_write & ~illegal_d;
            mem_to_reg_q <= bus.id_mem_to_reg;
        end
    end

    // Forwarding: EX/MEM wins over MEM/WB, register 0 is never forwarded
    assign fwd_rs = (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == rs_addr_q) ? bus.exmem_result :
                    (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == rs_addr_q) ? bus.memwb_result :
                    rs_data_q;
    assign fwd_rt = (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == rt_addr_q) ? bus.exmem_result :
                    (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == rt_addr_q) ? bus.memwb_result :
                    rt_data_q;

    assign bus.stall          = stall_c;
    assign bus.ex_valid       = valid_q;
    assign bus.ex_operand_a   = fwd_rs;
    assign bus.ex_operand_b   = alu_src_q ? imm_q : fwd_rt;
    assign bus.ex_store_data  = fwd_rt;
    assign bus.ex_shamt       = shamt_q;
    assign bus.ex_alu_control = alu_ctrl_q;
    assign bus.ex_dest        = dest_q;
    assign bus.ex_reg_write   = reg_write_q;
    assign bus.ex_mem_read    = mem_read_q;
    assign bus.ex_mem_write   = mem_write_q;
    assign bus.ex_mem_to_reg  = mem_to_reg_q;
endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Self-checking bench for id_ex_alu_stage: directed plan steps plus randomized traffic
// compared against a behavioural model of the EX-side instruction.
module tb_id_ex_alu_stage;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    id_ex_alu_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_alu_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction currently held in EX
    typedef struct {
        logic        valid;
        logic [3:0]  ctrl;
        logic [4:0]  dest;
        logic        rw, mr, mw, m2r;
        logic [4:0]  shamt;
        logic [4:0]  rs, rt;
        logic [31:0] rs_d, rt_d, imm;
        logic        src;
    } ex_t;

    ex_t m;
    logic exp_stall;

    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return 4'b0010;
        if (op == 2'd1) return 4'b0110;
        if (op == 2'd2) begin
            if (f == 6'b100000) return 4'b0010;
            if (f == 6'b100010) return 4'b0110;
            if (f == 6'b100100) return 4'b0000;
            if (f == 6'b100111) return 4'b1100;
            if (f == 6'b101010) return 4'b0111;
            if (f == 6'b000000) return 4'b1110;
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] d);
        if (bus.exmem_reg_write && bus.exmem_rd != 0 && bus.exmem_rd == a) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == a) return bus.memwb_result;
        return d;
    endfunction

    task automatic model_clear();
        m = '{valid: 1'b0, ctrl: 4'd0, dest: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0,
              shamt: 5'd0, rs: 5'd0, rt: 5'd0, rs_d: 32'd0, rt_d: 32'd0, imm: 32'd0, src: 1'b0};
    endtask

    task automatic model_clock();
        logic ill;
        if (bus.id_valid && !exp_stall && !bus.flush) begin
            m.ctrl  = ref_ctrl(bus.id_alu_op, bus.id_funct);
            ill     = (m.ctrl == 4'b1111);
            m.valid = 1'b1;
            m.dest  = bus.id_reg_dst ? bus.id_rd_addr : bus.id_rt_addr;
            m.rw    = bus.id_reg_write && !ill;
            m.mr    = bus.id_mem_read && !ill;
            m.mw    = bus.id_mem_write && !ill;
            m.m2r   = bus.id_mem_to_reg;
            m.shamt = bus.id_shamt;
            m.rs    = bus.id_rs_addr;
            m.rt    = bus.id_rt_addr;
            m.rs_d  = bus.id_rs_data;
            m.rt_d  = bus.id_rt_data;
            m.imm   = bus.id_imm;
            m.src   = bus.id_alu_src;
        end else begin
            model_clear();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] fa, fb;
        exp_stall = m.valid && m.mr && m.dest != 0 && bus.id_valid &&
                    (m.dest == bus.id_rs_addr ||
                     (m.dest == bus.id_rt_addr && (!bus.id_alu_src || bus.id_mem_write)));
        fa = ref_fwd(m.rs, m.rs_d);
        fb = ref_fwd(m.rt, m.rt_d);
        chk("valid",      32'(bus.ex_valid),       32'(m.valid));
        chk("alu_ctrl",   32'(bus.ex_alu_control), 32'(m.ctrl));
        chk("dest",       32'(bus.ex_dest),        32'(m.dest));
        chk("reg_write",  32'(bus.ex_reg_write),   32'(m.rw));
        chk("mem_read",   32'(bus.ex_mem_read),    32'(m.mr));
        chk("mem_write",  32'(bus.ex_mem_write),   32'(m.mw));
        chk("mem_to_reg", 32'(bus.ex_mem_to_reg),  32'(m.m2r));
        chk("shamt",      32'(bus.ex_shamt),       32'(m.shamt));
        chk("op_a",       bus.ex_operand_a,        fa);
        chk("op_b",       bus.ex_operand_b,        m.src ? m.imm : fb);
        chk("store",      bus.ex_store_data,       fb);
        chk("stall",      32'(bus.stall),          32'(exp_stall));
    endtask

    // Called at the falling edge with inputs already applied
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                          input logic src, input logic [31:0] imm, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic dst,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        bus.id_valid = v;      bus.id_alu_op = op;    bus.id_funct = f;       bus.id_shamt = sh;
        bus.id_alu_src = src;  bus.id_imm = imm;      bus.id_rs_data = rsd;   bus.id_rt_data = rtd;
        bus.id_rs_addr = rs;   bus.id_rt_addr = rt;   bus.id_rd_addr = rd;    bus.id_reg_dst = dst;
        bus.id_reg_write = rw; bus.id_mem_read = mr;  bus.id_mem_write = mw;  bus.id_mem_to_reg = m2r;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] er,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wr);
        bus.exmem_reg_write = ew; bus.exmem_rd = erd; bus.exmem_result = er;
        bus.memwb_reg_write = ww; bus.memwb_rd = wrd; bus.memwb_result = wr;
    endtask

    task automatic idle();
        set_id(1'b0, 2'd0, 6'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [5:0] legal_f [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100111, 6'b101010, 6'b000000};

    initial begin
        tests = 0;
        fails = 0;
        exp_stall = 1'b0;
        reset = 1'b1;
        bus.flush = 1'b0;
        idle();
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        step();
        chk("reset_valid", 32'(bus.ex_valid), 32'd0);

        // R-type add
        set_id(1'b1, 2'b10, 6'b100000, 5'd0, 1'b0, 32'h0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        #1;
        chk("add_ctrl", 32'(bus.ex_alu_control), 32'h2);
        chk("add_a", bus.ex_operand_a, 32'd5);
        chk("add_b", bus.ex_operand_b, 32'd7);
        chk("add_dest", 32'(bus.ex_dest), 32'd9);
        step();

        // sll then illegal funct
        set_id(1'b1, 2'b10, 6'b000000, 5'd4, 1'b0, 32'h0, 32'd1, 32'd2, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        set_id(1'b1, 2'b10, 6'b111111, 5'd0, 1'b0, 32'h0, 32'd1, 32'd2, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("sll_ctrl", 32'(bus.ex_alu_control), 32'hE);
        chk("sll_shamt", 32'(bus.ex_shamt), 32'd4);
        step();
        idle();
        #1;
        chk("ill_ctrl", 32'(bus.ex_alu_control), 32'hF);
        chk("ill_rw", 32'(bus.ex_reg_write), 32'd0);
        chk("ill_valid", 32'(bus.ex_valid), 32'd1);
        step();

        // Forwarding priority on rs=3
        set_id(1'b1, 2'b10, 6'b100000, 5'd0, 1'b0, 32'h0, 32'h11, 32'h22, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        set_fwd(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd3, 32'h12345678);
        #1; chk("fwd_exmem", bus.ex_operand_a, 32'hAAAA0000);
        set_fwd(1'b1, 5'd0, 32'hAAAA0000, 1'b1, 5'd3, 32'h12345678);
        #1; chk("fwd_memwb", bus.ex_operand_a, 32'h12345678);
        set_fwd(1'b1, 5'd0, 32'hAAAA0000, 1'b1, 5'd0, 32'h12345678);
        #1; chk("fwd_none", bus.ex_operand_a, 32'h11);
        step();

        // Load-use: lw $8, then add using $8
        set_id(1'b1, 2'b00, 6'd0, 5'd0, 1'b1, 32'h10, 32'h100, 32'h0, 5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        set_id(1'b1, 2'b10, 6'b100000, 5'd0, 1'b0, 32'h0, 32'h1, 32'h2, 5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1; chk("lu_stall", 32'(bus.stall), 32'd1);
        step();
        #1;
        chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
        chk("lu_stall_clr", 32'(bus.stall), 32'd0);
        step();
        idle();
        #1; chk("lu_add_dest", 32'(bus.ex_dest), 32'd10);
        step();

        // Flush with a valid ID instruction
        set_id(1'b1, 2'b10, 6'b100010, 5'd0, 1'b0, 32'h0, 32'h9, 32'h3, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        idle();
        #1; chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        step();

        // Async reset pulse between edges
        set_id(1'b1, 2'b10, 6'b100100, 5'd0, 1'b0, 32'h0, 32'h9, 32'h3, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        #1; chk("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
        #1; reset = 1'b1;
        #1; chk("async_rst_valid", 32'(bus.ex_valid), 32'd0);
        model_clear();
        #1; reset = 1'b0;
        @(negedge clk);
        set_id(1'b1, 2'b10, 6'b101010, 5'd0, 1'b0, 32'h0, 32'h4, 32'h5, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();

        // Randomized traffic with small register numbers to hit hazards and forwarding
        for (int i = 0; i < 400; i++) begin
            logic [1:0] op;
            logic [5:0] f;
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 7) < 6) ? legal_f[$urandom_range(0, 5)] : 6'($urandom);
            set_id(1'($urandom_range(0, 4) != 0), op, f, 5'($urandom), 1'($urandom), $urandom(), $urandom(),
                   $urandom(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            bus.flush = ($urandom_range(0, 9) == 0);
            set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom(),
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom());
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
